// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative shift-add multiply
// and restoring unsigned divide. Define ALU_MC_DIV_EN to include the divider.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             zero,
  output logic             div0
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t             state;
  logic [SW-1:0]      count;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   a_q;
  logic               hi_sel;
`ifdef ALU_MC_DIV_EN
  logic               div_sel;
`endif

  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   quick_z;
  logic               quick_div0;
  logic               is_iter;

  assign shamt = Y[SW-1:0];

  // Result of every op that completes in the accepting cycle.
  always_comb begin
    quick_z    = '0;
    quick_div0 = 1'b0;
    is_iter    = 1'b0;
    case (op)
      4'd0:  quick_z = X + Y;
      4'd1:  quick_z = X - Y;
      4'd2:  quick_z = X & Y;
      4'd3:  quick_z = X | Y;
      4'd4:  quick_z = X ^ Y;
      4'd5:  quick_z = X >> shamt;
      4'd6:  quick_z = X << shamt;
      4'd7:  quick_z = {{(WIDTH-1){1'b0}}, (X >= Y)};
      4'd8,
      4'd9:  is_iter = 1'b1;
`ifdef ALU_MC_DIV_EN
      4'd10: begin
        if (Y == '0) begin
          quick_z    = '1;
          quick_div0 = 1'b1;
        end else begin
          is_iter = 1'b1;
        end
      end
      4'd11: begin
        if (Y == '0) begin
          quick_z    = X;
          quick_div0 = 1'b1;
        end else begin
          is_iter = 1'b1;
        end
      end
`endif
      4'd12: quick_z = $unsigned($signed(X) >>> shamt);
      4'd13: quick_z = {{(WIDTH-1){1'b0}}, ($signed(X) >= $signed(Y))};
      default: quick_z = '0;
    endcase
  end

  // prod holds {high, low}: product accumulator and multiplier for multiply,
  // {partial remainder, dividend/quotient} for divide.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] iter_next;
  logic [WIDTH-1:0]   iter_z;

  assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, prod[WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH:0]     div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, a_q};
  assign div_rem   = div_ge ? (div_shift - {1'b0, a_q}) : div_shift;
  assign div_next  = {div_rem[WIDTH-1:0], prod[WIDTH-2:0], div_ge};
  assign iter_next = div_sel ? div_next : mul_next;
`else
  assign iter_next = mul_next;
`endif

  // Ops 9 and 11 take the upper half: product high word or remainder.
  assign iter_z = hi_sel ? iter_next[2*WIDTH-1:WIDTH] : iter_next[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      prod    <= '0;
      a_q     <= '0;
      hi_sel  <= 1'b0;
`ifdef ALU_MC_DIV_EN
      div_sel <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      Z       <= '0;
      zero    <= 1'b1;
      div0    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_iter) begin
              state  <= EXEC;
              busy   <= 1'b1;
              count  <= '0;
              hi_sel <= op[0];
`ifdef ALU_MC_DIV_EN
              div_sel <= op[1];
              if (op[1]) begin
                prod <= {{WIDTH{1'b0}}, X};
                a_q  <= Y;
              end else begin
                prod <= {{WIDTH{1'b0}}, Y};
                a_q  <= X;
              end
`else
              prod <= {{WIDTH{1'b0}}, Y};
              a_q  <= X;
`endif
            end else begin
              Z    <= quick_z;
              zero <= (quick_z == '0);
              div0 <= quick_div0;
              done <= 1'b1;
            end
          end
        end
        EXEC: begin
          prod <= iter_next;
          if (count == SW'(WIDTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            count <= '0;
            Z     <= iter_z;
            zero  <= (iter_z == '0);
            div0  <= 1'b0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus random ops compared
// against an arithmetic reference model (honours ALU_MC_DIV_EN).
module tb_alu_mc;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         busy;
  logic         done;
  logic [W-1:0] Z;
  logic         zero;
  logic         div0;

  int total = 0;
  int bad   = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op(op),
    .X(X),
    .Y(Y),
    .busy(busy),
    .done(done),
    .Z(Z),
    .zero(zero),
    .div0(div0)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result straight from the operation definitions.
  task automatic ref_model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] ez, output logic ed0, output logic iter);
    longint ua, ub, sa, sb, mask, r;
    int sh;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    mask = (longint'(1) << W) - 1;
    sh = int'(b) % W;
    ed0  = 1'b0;
    iter = 1'b0;
    r    = 0;
    case (o)
      4'd0:  r = ua + ub;
      4'd1:  r = ua - ub;
      4'd2:  r = ua & ub;
      4'd3:  r = ua | ub;
      4'd4:  r = ua ^ ub;
      4'd5:  r = ua >> sh;
      4'd6:  r = ua << sh;
      4'd7:  r = (ua >= ub) ? 1 : 0;
      4'd8:  begin r = ua * ub; iter = 1'b1; end
      4'd9:  begin r = (ua * ub) >> W; iter = 1'b1; end
`ifdef ALU_MC_DIV_EN
      4'd10: begin
        if (ub == 0) begin r = mask; ed0 = 1'b1; end
        else begin r = ua / ub; iter = 1'b1; end
      end
      4'd11: begin
        if (ub == 0) begin r = ua; ed0 = 1'b1; end
        else begin r = ua % ub; iter = 1'b1; end
      end
`endif
      4'd12: r = sa >>> sh;
      4'd13: r = (sa >= sb) ? 1 : 0;
      default: r = 0;
    endcase
    ez = W'(r & mask);
  endtask

  // Issue one op, follow the handshake, and check result and flags.
  // With poke set, a second start (op 0) is driven during EXEC and must be ignored.
  task automatic apply_stimulus(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit poke);
    logic [W-1:0] ez;
    logic         ed0;
    logic         iter;
    int           cycles;
    int           busy_low;
    ref_model(o, a, b, ez, ed0, iter);
    @(negedge clock);
    start = 1'b1;
    op    = o;
    X     = a;
    Y     = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    op    = 4'($urandom);
    X     = W'($urandom);
    Y     = W'($urandom);
    if (!iter) begin
      check_output($sformatf("op%0d done", o), 32'(done), 32'd1);
      check_output($sformatf("op%0d busy", o), 32'(busy), 32'd0);
    end else begin
      check_output($sformatf("op%0d busy_at_accept", o), 32'(busy), 32'd1);
      check_output($sformatf("op%0d done_at_accept", o), 32'(done), 32'd0);
      cycles   = 0;
      busy_low = 0;
      while (done !== 1'b1 && cycles < W + 4) begin
        if (poke && cycles == 2) begin
          @(negedge clock);
          start = 1'b1;
          op    = 4'd0;
          X     = 16'h0001;
          Y     = 16'h0001;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        cycles++;
        if (done !== 1'b1 && busy !== 1'b1) busy_low++;
      end
      check_output($sformatf("op%0d latency", o), 32'(cycles), 32'(W));
      check_output($sformatf("op%0d busy_gap", o), 32'(busy_low), 32'd0);
      check_output($sformatf("op%0d busy_at_done", o), 32'(busy), 32'd0);
    end
    check_output($sformatf("op%0d Z", o), 32'(Z), 32'(ez));
    check_output($sformatf("op%0d zero", o), 32'(zero), 32'(ez == '0));
    check_output($sformatf("op%0d div0", o), 32'(div0), 32'(ed0));
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    X     = '0;
    Y     = '0;
    repeat (2) @(posedge clock);
    #1;
    check_output("rst busy", 32'(busy), 32'd0);
    check_output("rst done", 32'(done), 32'd0);
    check_output("rst Z", 32'(Z), 32'd0);
    check_output("rst zero", 32'(zero), 32'd1);
    check_output("rst div0", 32'(div0), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] directed operations");
    apply_stimulus(4'd0, 16'h1234, 16'h0FFF, 1'b0);
    check_output("plan add value", 32'(Z), 32'h2233);
    apply_stimulus(4'd8, 16'h1234, 16'h5678, 1'b0);
    check_output("plan mul lo", 32'(Z), 32'h0060);
    apply_stimulus(4'd9, 16'h1234, 16'h5678, 1'b0);
    check_output("plan mul hi", 32'(Z), 32'h0626);
    apply_stimulus(4'd10, 16'd100, 16'd7, 1'b0);
    apply_stimulus(4'd11, 16'd100, 16'd7, 1'b0);
    apply_stimulus(4'd10, 16'h00AB, 16'h0000, 1'b0);
    apply_stimulus(4'd11, 16'h00AB, 16'h0000, 1'b0);
    apply_stimulus(4'd0, 16'h0000, 16'h0000, 1'b0);
    apply_stimulus(4'd0, 16'hFFFF, 16'h0001, 1'b0);
    apply_stimulus(4'd1, 16'h0000, 16'h0001, 1'b0);
    apply_stimulus(4'd5, 16'h8001, 16'h001F, 1'b0);
    apply_stimulus(4'd6, 16'h0003, 16'h000F, 1'b0);
    apply_stimulus(4'd13, 16'h8000, 16'h7FFF, 1'b0);
    apply_stimulus(4'd7, 16'h8000, 16'h7FFF, 1'b0);
    apply_stimulus(4'd14, 16'h1234, 16'h1234, 1'b0);
    apply_stimulus(4'd9, 16'hFFFF, 16'hFFFF, 1'b0);

    @(posedge clock);
    #1;
    check_output("done one cycle", 32'(done), 32'd0);

    $display("[TB] start during EXEC, then back-to-back start in done cycle");
    apply_stimulus(4'd8, 16'h1234, 16'h5678, 1'b1);
    check_output("poke mul lo", 32'(Z), 32'h0060);
    apply_stimulus(4'd0, 16'h0003, 16'h0004, 1'b0);

    $display("[TB] reset during EXEC");
    @(negedge clock);
    start = 1'b1;
    op    = 4'd9;
    X     = 16'h1234;
    Y     = 16'h5678;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    op    = 4'd0;
    X     = 16'h0005;
    Y     = 16'h0005;
    @(posedge clock);
    #1;
    check_output("abort busy", 32'(busy), 32'd0);
    check_output("abort done", 32'(done), 32'd0);
    check_output("abort Z", 32'(Z), 32'd0);
    check_output("abort zero", 32'(zero), 32'd1);
    check_output("abort div0", 32'(div0), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    pulses = 0;
    repeat (W + 2) begin
      @(posedge clock);
      #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check_output("abort no activity", 32'(pulses), 32'd0);
    apply_stimulus(4'd12, 16'h8000, 16'h0004, 1'b0);
    check_output("plan sra value", 32'(Z), 32'hF800);

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   ro;
      logic [W-1:0] rx;
      logic [W-1:0] ry;
      ro = 4'($urandom_range(0, 15));
      rx = W'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      apply_stimulus(ro, rx, ry, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised-width ALU for the next NBBPU core revision. It keeps the single-cycle arithmetic, logic, shift and compare operations, now registered, and adds iterative multiply and unsigned divide behind a start/busy/done handshake. Operands and opcode are latched on start, so the control unit can stall the pipeline on `busy` and capture `Z` on `done`.

## Interface
- `WIDTH`, 16: operand and result width, ≥ 4, power of two. Shift amount field SW = log2(WIDTH).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only when `busy` = 0.
- `op`  in  4  operation select, latched on accepted start.
- `X`  in  WIDTH  operand A, latched on accepted start.
- `Y`  in  WIDTH  operand B, latched on accepted start.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse; `Z` and flags valid from this cycle.
- `Z`  out  WIDTH  result; holds until next completion.
- `zero`  out  1  registered (Z == 0), updated with `Z`.
- `div0`  out  1  last completed op was divide/remainder with Y = 0.

## Operation
- Opcodes:
  - Single-cycle: 0 add; 1 sub; 2 and; 3 or; 4 xor; 5 shr logical by Y[SW-1:0]; 6 shl by Y[SW-1:0]; 7 unsigned X ≥ Y ? 1 : 0; 12 sra arithmetic by Y[SW-1:0]; 13 signed X ≥ Y ? 1 : 0; 14, 15 reserved → Z = 0.
  - Iterative: 8 mul low half; 9 mul high half; 10 unsigned quotient; 11 unsigned remainder.
- Add/sub wrap modulo 2^WIDTH. No carry or overflow output.
- Multiply: shift-add over WIDTH iterations into a 2·WIDTH-bit product, unsigned. Op 8 returns product[WIDTH-1:0]; op 9 returns product[2·WIDTH-1:WIDTH].
- Divide: restoring, one quotient bit per iteration, WIDTH iterations.
- Divide by zero (op 10/11 with Y = 0): no iteration; completes as a single-cycle op with `div0` = 1. Op 10 gives Z = all ones; op 11 gives Z = X.
- FSM states:
  - IDLE: start with a single-cycle or div-by-zero op completes immediately, stays in IDLE. Start with an iterative op goes to EXEC.
  - EXEC: counter runs 0..WIDTH-1; on last iteration Z is written, `done` asserted, state returns to IDLE.
- `start` while `busy` = 1 is ignored, with no queueing.
- `div0` is cleared on every completion of a non-faulting op.
- `X`, `Y` and `op` may change freely after acceptance.
- Reset values: state IDLE, `busy` 0, `done` 0, `Z` 0, `zero` 1, `div0` 0, counter 0.
- Reset mid-EXEC aborts the op: no `done` pulse, outputs take their reset values.

## Timing
- Start accepted at edge N:
  - Single-cycle (and div-by-zero): `Z`, `zero`, `div0` and `done` = 1 registered at edge N. `busy` stays 0. Latency 1.
  - Iterative: `busy` = 1 from edge N. Iterations at edges N+1..N+WIDTH. At edge N+WIDTH `busy` = 0, `done` = 1 and `Z` is valid. Latency WIDTH cycles (16 at default).
- `done` is high exactly one cycle. Back-to-back: start may be asserted in the `done` cycle and is accepted at the next edge.
- `busy` and `done` are never both high.
- Reset has priority over start in the same cycle.

## Configuration
- `ALU_MC_DIV_EN`:
  - Defined: ops 10/11 run the iterative divider as above.
  - Undefined: divider logic is omitted. Ops 10/11 behave as reserved: single-cycle, Z = 0, `div0` = 0.
- Multiply is always present.

## Test plan
- Reset, then start op 0 with X = 16'h1234, Y = 16'h0FFF → `done` at next edge, Z = 16'h2233, `zero` = 0, `busy` never high.
- Op 8, then op 9, with X = 16'h1234, Y = 16'h5678 → each has `busy` for 16 cycles, then one `done`; Z = 16'h0060, then 16'h0626.
- Op 10 and op 11 with X = 16'd100, Y = 16'd7 (DIV_EN defined) → Z = 16'h000E, then 16'h0002, each after 16 cycles, `div0` = 0. With the macro undefined → Z = 0 after 1 cycle.
- Op 10 and op 11 with X = 16'h00AB, Y = 0 → 1-cycle completion, `div0` = 1, Z = 16'hFFFF, then 16'h00AB. Following op 0 with X = Y = 0 → `div0` = 0, `zero` = 1.
- Start op 8; re-assert start with op 0 at cycle 3 of EXEC → ignored, multiply result still correct after 16 cycles. Start op 0 in the `done` cycle → accepted, `done` again one cycle later.
- Start op 9; assert reset at cycle 5 → `busy` = 0, Z = 0, no `done` pulse. Next op 12 with X = 16'h8000, Y = 4 → Z = 16'hF800.
